// File: rtl/lsu_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ram_ctrl
// Purpose  : Load/store access unit in front of the data RAM. Accepts one
//            core load/store at a time, turns it into a word-aligned RAM
//            transaction (byte enables, lane-replicated write data), runs the
//            RAM valid/ready handshake and waits for read data, then returns a
//            one-cycle response with extended load data or an error flag.
// Ports    : clk, rst                   clock, synchronous active-high reset
//            req_*                      core request channel (valid/ready)
//            resp_*                     core response (one-cycle pulse)
//            ram_*_out, valid_out       registered RAM request side
//            ready_in, rdata_valid_in,
//            ram_read_data_in           RAM handshake and read data
// Revision : 1.0  initial release
// ============================================================================
module lsu_ram_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_is_store_in,
  input  logic [2:0]  req_funct3_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  output logic [31:0] ram_addr_out,
  output logic [31:0] ram_write_data_out,
  output logic        ram_read_en_out,
  output logic        ram_write_en_out,
  output logic [3:0]  ram_write_byte_en_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        rdata_valid_in,
  input  logic [31:0] ram_read_data_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  // Timeout fires at the end of the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT.
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 is_store_q, is_store_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           offs_q, offs_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic [31:0]          ram_addr_q, ram_addr_d;
  logic [31:0]          ram_wdata_q, ram_wdata_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic [3:0]           be_q, be_d;
  logic                 valid_q, valid_d;

  logic                 w_bad;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic                 w_timeout;

  // Align the addressed lane down to bit 0, then extend by width/sign code.
  function automatic logic [31:0] f_extend(input logic [2:0]  f3,
                                           input logic [1:0]  offs,
                                           input logic [31:0] data);
    logic [31:0] sh;
    sh = data >> {offs, 3'b000};
    case (f3)
      3'b000:  f_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  f_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  f_extend = {24'd0, sh[7:0]};
      3'b101:  f_extend = {16'd0, sh[15:0]};
      default: f_extend = sh;
    endcase
  endfunction

  // Request decode: legality, alignment, byte lanes and replicated data.
  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b1111;
    w_wdata = req_wdata_in;
    case (req_funct3_in[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr_in[1:0];
        w_wdata = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << req_addr_in[1:0];
        w_wdata = {2{req_wdata_in[15:0]}};
        w_bad   = req_addr_in[0];
      end
      2'b10: begin
        w_bad   = (req_addr_in[1:0] != 2'b00) || req_funct3_in[2];
      end
      default: begin
        w_bad   = 1'b1;
      end
    endcase
    if (req_is_store_in && req_funct3_in[2]) begin
      w_bad = 1'b1;
    end
  end

  assign w_timeout = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    offs_d       = offs_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    be_d         = be_q;
    valid_d      = valid_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_in && req_ready_q) begin
          is_store_d  = req_is_store_in;
          funct3_d    = req_funct3_in;
          offs_d      = req_addr_in[1:0];
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (w_bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            valid_d     = 1'b1;
            rd_en_d     = !req_is_store_in;
            wr_en_d     = req_is_store_in;
            be_d        = req_is_store_in ? w_be : 4'b0000;
            ram_addr_d  = {req_addr_in[31:2], 2'b00};
            ram_wdata_d = req_is_store_in ? w_wdata : 32'd0;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        // A handshake in the final allowed cycle still completes normally.
        if (ready_in || w_timeout) begin
          valid_d = 1'b0;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          be_d    = 4'b0000;
          cnt_d   = '0;
        end
        if (ready_in) begin
          if (is_store_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end else if (rdata_valid_in) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = f_extend(funct3_q, offs_q, ram_read_data_in);
          end else begin
            state_d = S_WAIT;
          end
        end else if (w_timeout) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (rdata_valid_in) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = f_extend(funct3_q, offs_q, ram_read_data_in);
          cnt_d        = '0;
        end else if (w_timeout) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          cnt_d        = '0;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        valid_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        be_d        = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      offs_q       <= 2'd0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      ram_addr_q   <= 32'd0;
      ram_wdata_q  <= 32'd0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      be_q         <= 4'b0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      offs_q       <= offs_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      be_q         <= be_d;
      valid_q      <= valid_d;
    end
  end

  assign req_ready_out         = req_ready_q;
  assign resp_valid_out        = resp_valid_q;
  assign resp_rdata_out        = resp_rdata_q;
  assign resp_err_out          = resp_err_q;
  assign ram_addr_out          = ram_addr_q;
  assign ram_write_data_out    = ram_wdata_q;
  assign ram_read_en_out       = rd_en_q;
  assign ram_write_en_out      = wr_en_q;
  assign ram_write_byte_en_out = be_q;
  assign valid_out             = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ram_ctrl
// Purpose  : Directed self-checking bench for lsu_ram_ctrl. A second instance
//            with a short timeout exercises the timeout path.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_is_store_in = 1'b0;
  logic [2:0]  req_funct3_in = 3'd0;
  logic [31:0] req_addr_in = 32'd0;
  logic [31:0] req_wdata_in = 32'd0;
  logic        ready_in = 1'b0;
  logic        rdata_valid_in = 1'b0;
  logic [31:0] ram_read_data_in = 32'd0;

  logic        req_ready_out, resp_valid_out, resp_err_out;
  logic [31:0] resp_rdata_out, ram_addr_out, ram_write_data_out;
  logic        ram_read_en_out, ram_write_en_out, valid_out;
  logic [3:0]  ram_write_byte_en_out;

  // Short-timeout instance: own request valid and RAM handshake inputs.
  logic        t_req_valid_in = 1'b0;
  logic        t_ready_in = 1'b0;
  logic        t_rdata_valid_in = 1'b0;
  logic        t_req_ready_out, t_resp_valid_out, t_resp_err_out;
  logic [31:0] t_resp_rdata_out, t_ram_addr_out, t_ram_write_data_out;
  logic        t_ram_read_en_out, t_ram_write_en_out, t_valid_out;
  logic [3:0]  t_ram_write_byte_en_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_is_store_in(req_is_store_in), .req_funct3_in(req_funct3_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
    .resp_err_out(resp_err_out), .ram_addr_out(ram_addr_out),
    .ram_write_data_out(ram_write_data_out), .ram_read_en_out(ram_read_en_out),
    .ram_write_en_out(ram_write_en_out),
    .ram_write_byte_en_out(ram_write_byte_en_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .rdata_valid_in(rdata_valid_in), .ram_read_data_in(ram_read_data_in)
  );

  lsu_ram_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(16)) dut_to (
    .clk(clk), .rst(rst),
    .req_valid_in(t_req_valid_in), .req_ready_out(t_req_ready_out),
    .req_is_store_in(req_is_store_in), .req_funct3_in(req_funct3_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .resp_valid_out(t_resp_valid_out), .resp_rdata_out(t_resp_rdata_out),
    .resp_err_out(t_resp_err_out), .ram_addr_out(t_ram_addr_out),
    .ram_write_data_out(t_ram_write_data_out),
    .ram_read_en_out(t_ram_read_en_out), .ram_write_en_out(t_ram_write_en_out),
    .ram_write_byte_en_out(t_ram_write_byte_en_out),
    .valid_out(t_valid_out), .ready_in(t_ready_in),
    .rdata_valid_in(t_rdata_valid_in), .ram_read_data_in(ram_read_data_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_is_store_in = st;
    req_funct3_in   = f3;
    req_addr_in     = addr;
    req_wdata_in    = wd;
    req_valid_in    = 1'b1;
    tick();
    req_valid_in    = 1'b0;
  endtask

  // Zero-wait access (loads get data coincident with ready).
  task automatic access(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    ready_in         = 1'b1;
    rdata_valid_in   = !st;
    ram_read_data_in = rd;
    issue(st, f3, addr, wd);
    check({tag, " c1 valid_out"}, 32'(valid_out), 32'd1);
    check({tag, " c1 write_en"},  32'(ram_write_en_out), 32'(st));
    check({tag, " c1 read_en"},   32'(ram_read_en_out), 32'(!st));
    check({tag, " c1 byte_en"},   32'(ram_write_byte_en_out), 32'(exp_be));
    check({tag, " c1 ram_addr"},  ram_addr_out, {addr[31:2], 2'b00});
    if (st) check({tag, " c1 wdata"}, ram_write_data_out, exp_wd);
    check({tag, " c1 resp_valid"}, 32'(resp_valid_out), 32'd0);
    tick();
    check({tag, " c2 resp_valid"}, 32'(resp_valid_out), 32'd1);
    check({tag, " c2 resp_err"},   32'(resp_err_out), 32'd0);
    check({tag, " c2 resp_rdata"}, resp_rdata_out, exp_rd);
    check({tag, " c2 valid_out"},  32'(valid_out), 32'd0);
    check({tag, " c2 req_ready"},  32'(req_ready_out), 32'd0);
    rdata_valid_in = 1'b0;
    tick();
    check({tag, " c3 resp_valid"}, 32'(resp_valid_out), 32'd0);
    check({tag, " c3 req_ready"},  32'(req_ready_out), 32'd1);
  endtask

  task automatic err_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr);
    ready_in = 1'b1;
    issue(st, f3, addr, 32'hDEADBEEF);
    check({tag, " c1 resp_valid"}, 32'(resp_valid_out), 32'd1);
    check({tag, " c1 resp_err"},   32'(resp_err_out), 32'd1);
    check({tag, " c1 resp_rdata"}, resp_rdata_out, 32'd0);
    check({tag, " c1 valid_out"},  32'(valid_out), 32'd0);
    check({tag, " c1 enables"},    32'({ram_read_en_out, ram_write_en_out}), 32'd0);
    tick();
    check({tag, " c2 resp_valid"}, 32'(resp_valid_out), 32'd0);
    check({tag, " c2 valid_out"},  32'(valid_out), 32'd0);
    tick();
    check({tag, " c3 req_ready"},  32'(req_ready_out), 32'd1);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst req_ready",  32'(req_ready_out), 32'd1);
    check("rst valid_out",  32'(valid_out), 32'd0);
    check("rst resp_valid", 32'(resp_valid_out), 32'd0);
    check("rst ram_addr",   ram_addr_out, 32'd0);
    check("rst byte_en",    32'(ram_write_byte_en_out), 32'd0);
    check("rst t_req_ready", 32'(t_req_ready_out), 32'd1);
    rst = 1'b0;
    tick();

    // Word round trip.
    access("SW 08",  1'b1, 3'b010, 32'h08, 32'hFFFF0000, 32'h0, 4'b1111, 32'hFFFF0000, 32'h0);
    access("LW 08",  1'b0, 3'b010, 32'h08, 32'h0, 32'hFFFF0000, 4'b0000, 32'h0, 32'hFFFF0000);
    // Byte store/load.
    access("SB 0D",  1'b1, 3'b000, 32'h0D, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    access("LB 0D",  1'b0, 3'b000, 32'h0D, 32'h0, 32'h0000A500, 4'b0000, 32'h0, 32'hFFFFFFA5);
    access("LBU 0D", 1'b0, 3'b100, 32'h0D, 32'h0, 32'h0000A500, 4'b0000, 32'h0, 32'h000000A5);
    // Halfword sign handling and halfword store lanes.
    access("LH 0E",  1'b0, 3'b001, 32'h0E, 32'h0, 32'h80010000, 4'b0000, 32'h0, 32'hFFFF8001);
    access("LHU 0E", 1'b0, 3'b101, 32'h0E, 32'h0, 32'h80010000, 4'b0000, 32'h0, 32'h00008001);
    access("SH 12",  1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 4'b1100, 32'h12341234, 32'h0);
    access("LB 13",  1'b0, 3'b000, 32'h13, 32'h0, 32'h7F000000, 4'b0000, 32'h0, 32'h0000007F);

    // Errors: misaligned and illegal.
    err_access("LH 03 misal",  1'b0, 3'b001, 32'h03);
    err_access("SB f3=100",    1'b1, 3'b100, 32'h10);
    err_access("LW 02 misal",  1'b0, 3'b010, 32'h02);
    err_access("L f3=011",     1'b0, 3'b011, 32'h00);

    // Wait states: ready low 3 cycles, rdata 2 cycles after ready.
    ready_in = 1'b0;
    rdata_valid_in = 1'b0;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("wait c%0d valid_out", i), 32'(valid_out), 32'd1);
      check($sformatf("wait c%0d ram_addr", i), ram_addr_out, 32'h20);
      check($sformatf("wait c%0d read_en", i), 32'(ram_read_en_out), 32'd1);
      if (i == 4) ready_in = 1'b1;
      tick();
    end
    ready_in = 1'b0;
    check("wait c5 valid_out", 32'(valid_out), 32'd0);
    check("wait c5 resp_valid", 32'(resp_valid_out), 32'd0);
    tick();
    rdata_valid_in = 1'b1;
    ram_read_data_in = 32'h12345678;
    check("wait c6 resp_valid", 32'(resp_valid_out), 32'd0);
    tick();
    rdata_valid_in = 1'b0;
    check("wait c7 resp_valid", 32'(resp_valid_out), 32'd1);
    check("wait c7 resp_rdata", resp_rdata_out, 32'h12345678);
    check("wait c7 resp_err", 32'(resp_err_out), 32'd0);
    tick();
    tick();

    // Timeout on the TIMEOUT_CYCLES=4 instance: ready never asserted.
    t_ready_in = 1'b0;
    req_is_store_in = 1'b0;
    req_funct3_in = 3'b010;
    req_addr_in = 32'h40;
    t_req_valid_in = 1'b1;
    tick();
    t_req_valid_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to c%0d valid_out", i), 32'(t_valid_out), 32'd1);
      check($sformatf("to c%0d resp_valid", i), 32'(t_resp_valid_out), 32'd0);
      tick();
    end
    check("to c5 valid_out", 32'(t_valid_out), 32'd0);
    check("to c5 resp_valid", 32'(t_resp_valid_out), 32'd1);
    check("to c5 resp_err", 32'(t_resp_err_out), 32'd1);
    check("to c5 resp_rdata", t_resp_rdata_out, 32'd0);
    tick();
    check("to c6 resp_valid", 32'(t_resp_valid_out), 32'd0);
    tick();
    check("to c7 req_ready", 32'(t_req_ready_out), 32'd1);

    // Reset mid-REQ abandons the transaction.
    ready_in = 1'b0;
    issue(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
    check("rstmid c1 valid_out", 32'(valid_out), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_in = 1'b1;
    check("rstmid valid_out", 32'(valid_out), 32'd0);
    check("rstmid write_en", 32'(ram_write_en_out), 32'd0);
    check("rstmid req_ready", 32'(req_ready_out), 32'd1);
    check("rstmid resp_valid", 32'(resp_valid_out), 32'd0);
    tick();
    check("rstmid +1 resp_valid", 32'(resp_valid_out), 32'd0);
    check("rstmid +1 valid_out", 32'(valid_out), 32'd0);

    // Recovery after reset.
    access("LHU 02", 1'b0, 3'b101, 32'h02, 32'h0, 32'hBEEF0000, 4'b0000, 32'h0, 32'h0000BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
Load/store access unit sitting directly upstream of the data `ram` block. It accepts one core load/store request at a time and converts it to a word-aligned RAM transaction with byte enables and lane-replicated write data. It drives the RAM valid/ready handshake and waits for read data. It returns loads sign- or zero-extended, and reports misaligned, illegal and timed-out accesses as errors.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for `ready_in` or `rdata_valid_in` before an error response; 0 disables the timeout.
CNT_WIDTH, 16, width of the timeout counter; TIMEOUT_CYCLES must fit in it.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid_in  in  1  core request valid
req_ready_out  out  1  unit can accept a request; high only in IDLE
req_is_store_in  in  1  1 = store, 0 = load
req_funct3_in  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr_in  in  32  byte address
req_wdata_in  in  32  store data, LSB-aligned
resp_valid_out  out  1  one-cycle response pulse
resp_rdata_out  out  32  extended load data; 0 for stores and errors
resp_err_out  out  1  error flag, qualified by resp_valid_out
ram_addr_out  out  32  word address {addr[31:2],2'b00}
ram_write_data_out  out  32  lane-replicated store data
ram_read_en_out  out  1  read enable
ram_write_en_out  out  1  write enable
ram_write_byte_en_out  out  4  byte enables
valid_out  out  1  to ram valid_in
ready_in  in  1  from ram ready_out
rdata_valid_in  in  1  from ram rdata_valid_out
ram_read_data_in  in  32  from ram ram_read_data_out

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except `req_ready_out` = 1. Timeout counter cleared.
- Reset mid-operation: the transaction is abandoned. `valid_out` and the enables are 0 in the cycle after rst is sampled. No response is issued.
- Request acceptance: on `req_valid_in && req_ready_out` at cycle 0, the request is latched. All RAM-side outputs are registered.
- Checks, evaluated at acceptance:
  - Misaligned: H with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal: funct3 011/110/111; store with funct3 1xx.
  - Either case goes to RESP with err = 1 and no RAM access. `resp_valid_out` = 1 in cycle 1.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 << addr[1:0].
  - W: 4'b1111.
  - Loads drive 4'b0000.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- State REQ (entered cycle 1):
  - `valid_out` = 1, with exactly one of `ram_read_en_out`/`ram_write_en_out` high.
  - Address, data and enables are held stable until `ready_in` = 1 is sampled.
  - On that edge, `valid_out` and the enables drop.
  - Store goes to RESP. Load goes to WAIT, or directly to RESP if `rdata_valid_in` is 1 in the same cycle as `ready_in`.
- State WAIT: on `rdata_valid_in` = 1, `ram_read_data_in` is captured and the state goes to RESP.
- Load extraction: shift right by addr[1:0]*8, then extend.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- State RESP:
  - `resp_valid_out` = 1 for exactly one cycle, then IDLE.
  - `req_ready_out` returns to 1 in the following cycle; back-to-back requests are therefore 1 idle cycle apart.
- Latency with zero-wait RAM: store response at cycle 2; load response at cycle 2 if data is coincident with ready, otherwise (rdata cycle)+1.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears on state entry.
  - When it reaches TIMEOUT_CYCLES (≠0): drop `valid_out`, go to RESP with err = 1 and rdata = 0.
- Stray inputs: `rdata_valid_in` outside WAIT/REQ and `ready_in` outside REQ are ignored.
- Request inputs are don't-care while `req_ready_out` = 0.

Test Plan:
- Word round trip: SW addr 0x08, wdata 0xffff0000, ready_in tied 1.
  - Cycle 1: valid_out = 1, write_en = 1, be = 1111, ram_addr = 0x08.
  - resp_valid at cycle 2, err = 0.
  - Follow with LW 0x08 and rdata 0xffff0000 → resp_rdata = 0xffff0000.
- Byte store/load: SB addr 0x0D, wdata 0x000000A5 → be = 0010, ram_write_data = 0xA5A5A5A5, ram_addr = 0x0C.
  - LB 0x0D with ram data 0x0000A500 → 0xFFFFFFA5.
  - LBU → 0x000000A5.
- Halfword sign: LH 0x0E with ram data 0x80010000 → 0xFFFF8001; LHU → 0x00008001.
- Errors:
  - LH addr 0x03 → resp_valid cycle 1, err = 1, valid_out never asserted.
  - Store funct3 100 → same response.
- Wait states: ready_in held low 3 cycles, then rdata_valid 2 cycles later.
  - valid_out and address are stable for 4 cycles.
  - Response is 1 cycle after rdata_valid.
- Timeout/reset:
  - TIMEOUT_CYCLES = 4, ready_in never asserted → err response after 4 cycles in REQ.
  - rst pulsed mid-REQ → valid_out = 0 next cycle, req_ready_out = 1, no resp_valid.
